wb_reg_file: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface: consumes the MEM_WB register outputs,

---
 rtl/wb_reg_file.sv | 54 +++++
 tb/tb_wb_reg_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// wb_reg_file: MEM/WB write-back select, 2**ADDR_W x DATA_W register file, two async read ports
// Ports:
//   clk_i, rst_i (async active-low)
//   MemtoReg_i, RegWrite_i, data_i, alu_result_i, RDaddr_i : MEM_WB write-back inputs
//   RS1addr_i, RS2addr_i -> RS1data_o, RS2data_o           : combinational reads, x0 reads 0
//   wb_data_o, wb_valid_o                                   : selected value / effective write
//   wb_count_o                                              : committed writes since reset
// Option: define WB_RF_BYPASS_EN to return the write-back value on a same-cycle read of RDaddr_i.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_valid_o,
  output logic [CNT_W-1:0]  wb_count_o
);
`ifdef WB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byp1, byp2;
  assign wb_data_o  = MemtoReg_i ? data_i : alu_result_i;
  assign wb_valid_o = RegWrite_i && RDaddr_i != '0;
  assign cnt_d      = cnt_q + CNT_W'(wb_valid_o);
  assign wb_count_o = cnt_q;
  // bypass is gated by rst_i so reads stay 0 throughout reset
  assign byp1 = BYP && rst_i && wb_valid_o && RS1addr_i == RDaddr_i;
  assign byp2 = BYP && rst_i && wb_valid_o && RS2addr_i == RDaddr_i;
  assign RS1data_o = RS1addr_i == '0 ? '0 : byp1 ? wb_data_o : regs_q[RS1addr_i];
  assign RS2data_o = RS2addr_i == '0 ? '0 : byp2 ? wb_data_o : regs_q[RS2addr_i];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_valid_o) regs_q[RDaddr_i] <= wb_data_o;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed and random checks of wb_reg_file against a register/counter model
module tb_wb_reg_file;
  logic        clk_i = 0, rst_i = 1, MemtoReg_i = 0, RegWrite_i = 0;
  logic [31:0] data_i = 0, alu_result_i = 0;
  logic [4:0]  RDaddr_i = 0, RS1addr_i = 0, RS2addr_i = 0;
  logic [31:0] RS1data_o, RS2data_o, wb_data_o, wb_count_o;
  logic        wb_valid_o;
  logic [31:0] r1b, r2b, wbb;
  logic        wvb;
  logic [3:0]  cnt4;
  int          nchk = 0, nerr = 0;
  logic [31:0] m [32];
  logic [31:0] mcnt;
  logic [3:0]  mcnt4;
`ifdef WB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  wb_reg_file dut (.clk_i(clk_i), .rst_i(rst_i), .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
    .data_i(data_i), .alu_result_i(alu_result_i), .RDaddr_i(RDaddr_i), .RS1addr_i(RS1addr_i),
    .RS2addr_i(RS2addr_i), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .wb_data_o(wb_data_o),
    .wb_valid_o(wb_valid_o), .wb_count_o(wb_count_o));
  wb_reg_file #(.CNT_W(4)) dut4 (.clk_i(clk_i), .rst_i(rst_i), .MemtoReg_i(MemtoReg_i),
    .RegWrite_i(RegWrite_i), .data_i(data_i), .alu_result_i(alu_result_i), .RDaddr_i(RDaddr_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RS1data_o(r1b), .RS2data_o(r2b),
    .wb_data_o(wbb), .wb_valid_o(wvb), .wb_count_o(cnt4));
  always #5 clk_i = ~clk_i;
  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 0;
    mcnt = 0;
    mcnt4 = 0;
  endtask
  task automatic drive(input logic we, input logic mtr, input logic [31:0] d, input logic [31:0] a,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    RegWrite_i = we; MemtoReg_i = mtr; data_i = d; alu_result_i = a;
    RDaddr_i = rd; RS1addr_i = r1; RS2addr_i = r2;
  endtask
  task automatic step();
    if (rst_i && RegWrite_i && RDaddr_i != 0) begin
      m[RDaddr_i] = MemtoReg_i ? data_i : alu_result_i;
      mcnt++;
      mcnt4++;
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    drive(1, 0, 0, 32'h1234, 5, 5, 5);
    step();
    RegWrite_i = 0;
    #1;
    nchk++; if (RS1data_o !== 32'h1234) begin nerr++; $display("FAIL x5_write got=%h exp=%h", RS1data_o, 32'h1234); end
    drive(1, 0, 0, 32'h9999, 5, 5, 5);
    rst_i = 0;
    #1;
    nchk++; if (RS1data_o !== 0) begin nerr++; $display("FAIL rst_async_read got=%h exp=0", RS1data_o); end
    nchk++; if (wb_count_o !== 0) begin nerr++; $display("FAIL rst_count got=%0d exp=0", wb_count_o); end
    @(posedge clk_i);
    #1;
    nchk++; if (RS2data_o !== 0) begin nerr++; $display("FAIL rst_blocks_write got=%h exp=0", RS2data_o); end
    nchk++; if (wb_count_o !== 0) begin nerr++; $display("FAIL rst_blocks_count got=%0d exp=0", wb_count_o); end
    rst_i = 1;
    model_clear();
    RegWrite_i = 0;
    #1;
    nchk++; if (RS1data_o !== 0) begin nerr++; $display("FAIL post_rst_read got=%h exp=0", RS1data_o); end
  endtask
  task automatic test_select();
    drive(1, 1, 32'hDEADBEEF, 32'h11, 7, 7, 8);
    #1;
    nchk++; if (wb_data_o !== 32'hDEADBEEF) begin nerr++; $display("FAIL wb_data_mem got=%h exp=deadbeef", wb_data_o); end
    nchk++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL wb_valid got=%b exp=1", wb_valid_o); end
    step();
    drive(1, 0, 32'hDEADBEEF, 32'h11, 8, 7, 8);
    #1;
    nchk++; if (wb_data_o !== 32'h11) begin nerr++; $display("FAIL wb_data_alu got=%h exp=11", wb_data_o); end
    nchk++; if (RS1data_o !== 32'hDEADBEEF) begin nerr++; $display("FAIL x7 got=%h exp=deadbeef", RS1data_o); end
    step();
    RegWrite_i = 0;
    #1;
    nchk++; if (RS2data_o !== 32'h11) begin nerr++; $display("FAIL x8 got=%h exp=11", RS2data_o); end
    nchk++; if (wb_count_o !== 2) begin nerr++; $display("FAIL count2 got=%0d exp=2", wb_count_o); end
  endtask
  task automatic test_x0();
    drive(1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    #1;
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL x0_valid got=%b exp=0", wb_valid_o); end
    nchk++; if (RS1data_o !== 0) begin nerr++; $display("FAIL x0_same_cycle got=%h exp=0", RS1data_o); end
    step();
    RegWrite_i = 0;
    #1;
    nchk++; if (RS1data_o !== 0) begin nerr++; $display("FAIL x0_read got=%h exp=0", RS1data_o); end
    nchk++; if (wb_count_o !== 2) begin nerr++; $display("FAIL x0_count got=%0d exp=2", wb_count_o); end
  endtask
  task automatic test_bypass();
    logic [31:0] e;
    drive(1, 0, 0, 32'hA, 3, 0, 0);
    step();
    drive(1, 0, 0, 32'hB, 3, 3, 3);
    #1;
    e = BYP ? 32'hB : 32'hA;
    nchk++; if (RS1data_o !== e) begin nerr++; $display("FAIL byp_rs1 got=%h exp=%h", RS1data_o, e); end
    nchk++; if (RS2data_o !== e) begin nerr++; $display("FAIL byp_rs2 got=%h exp=%h", RS2data_o, e); end
    step();
    RegWrite_i = 0;
    #1;
    nchk++; if (RS1data_o !== 32'hB) begin nerr++; $display("FAIL next_rs1 got=%h exp=b", RS1data_o); end
    nchk++; if (RS2data_o !== 32'hB) begin nerr++; $display("FAIL next_rs2 got=%h exp=b", RS2data_o); end
    nchk++; if (wb_count_o !== 4) begin nerr++; $display("FAIL count4 got=%0d exp=4", wb_count_o); end
  endtask
  task automatic test_bubble_wrap();
    drive(0, 0, 0, 32'h55, 9, 9, 9);
    step();
    nchk++; if (RS1data_o !== 0) begin nerr++; $display("FAIL bubble_x9 got=%h exp=0", RS1data_o); end
    nchk++; if (wb_count_o !== 4) begin nerr++; $display("FAIL bubble_count got=%0d exp=4", wb_count_o); end
    rst_i = 0;
    #1;
    rst_i = 1;
    model_clear();
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 32'(i), 5'(1 + i % 31), 0, 0);
      step();
    end
    nchk++; if (cnt4 !== 4'd15) begin nerr++; $display("FAIL cnt4_15 got=%0d exp=15", cnt4); end
    drive(1, 0, 0, 32'h77, 20, 0, 0);
    step();
    RegWrite_i = 0;
    #1;
    nchk++; if (cnt4 !== 4'd0) begin nerr++; $display("FAIL cnt4_wrap got=%0d exp=0", cnt4); end
    nchk++; if (wb_count_o !== 16) begin nerr++; $display("FAIL count16 got=%0d exp=16", wb_count_o); end
  endtask
  task automatic test_random();
    logic [31:0] e1, e2, ew;
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) RS1addr_i = RDaddr_i;
      #1;
      ew = MemtoReg_i ? data_i : alu_result_i;
      e1 = RS1addr_i == 0 ? 0 : (BYP && RegWrite_i && RDaddr_i != 0 && RDaddr_i == RS1addr_i) ? ew : m[RS1addr_i];
      e2 = RS2addr_i == 0 ? 0 : (BYP && RegWrite_i && RDaddr_i != 0 && RDaddr_i == RS2addr_i) ? ew : m[RS2addr_i];
      nchk++; if (RS1data_o !== e1) begin nerr++; $display("FAIL rnd_rs1 c=%0d got=%h exp=%h", c, RS1data_o, e1); end
      nchk++; if (RS2data_o !== e2) begin nerr++; $display("FAIL rnd_rs2 c=%0d got=%h exp=%h", c, RS2data_o, e2); end
      nchk++; if (wb_data_o !== ew) begin nerr++; $display("FAIL rnd_wb c=%0d got=%h exp=%h", c, wb_data_o, ew); end
      nchk++; if (wb_valid_o !== (RegWrite_i && RDaddr_i != 0)) begin nerr++; $display("FAIL rnd_valid c=%0d got=%b", c, wb_valid_o); end
      nchk++; if (wb_count_o !== mcnt) begin nerr++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, wb_count_o, mcnt); end
      nchk++; if (cnt4 !== mcnt4) begin nerr++; $display("FAIL rnd_cnt4 c=%0d got=%0d exp=%0d", c, cnt4, mcnt4); end
      step();
    end
  endtask
  initial begin
    model_clear();
    #2 rst_i = 0;
    #20;
    nchk++; if (wb_count_o !== 0) begin nerr++; $display("FAIL init_count got=%0d exp=0", wb_count_o); end
    nchk++; if (cnt4 !== 0) begin nerr++; $display("FAIL init_cnt4 got=%0d exp=0", cnt4); end
    @(posedge clk_i);
    #2 rst_i = 1;
    test_reset();
    test_select();
    test_x0();
    test_bypass();
    test_bubble_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
